// File: rtl/audio_i2s_tx_pkg.sv
// Shared sound-path definitions: I2S frame geometry, the sample type and the
// conversion from the sound block's sample format to the two's-complement wire format.
package audio_i2s_tx_pkg;

   localparam int I2S_SLOT_BITS  = 16;
   localparam int I2S_FRAME_BITS = 32;

   typedef logic [15:0] audio_sample_t;

   // Offset-binary samples become two's complement by flipping the MSB.
   function automatic audio_sample_t to_tx_word(input audio_sample_t s, input bit signed_in);
      return signed_in ? s : {~s[15], s[14:0]};
   endfunction

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Connection between the sound block (master) and the I2S transmitter (slave),
// carrying the sample strobe, the I2S pins, the error pulses and debug state.
interface audio_i2s_tx_if;
   import audio_i2s_tx_pkg::*;

   // clk_24KHz_en is a valid-only strobe with no ready: a sample offered while the
   // FIFO is full (and not being popped that same clk) is dropped and flagged on overrun.
   logic          clk_24KHz_en;
   audio_sample_t audio;
   logic          mute;
   logic          i2s_bclk;
   logic          i2s_lrck;
   logic          i2s_data;
   logic          overrun;
   logic          underrun;
   logic [4:0]    dbg_bit_idx;
   logic [1:0]    dbg_fifo_count;

   modport master (
      output clk_24KHz_en, audio, mute,
      input  i2s_bclk, i2s_lrck, i2s_data, overrun, underrun, dbg_bit_idx, dbg_fifo_count
   );

   modport slave (
      input  clk_24KHz_en, audio, mute,
      output i2s_bclk, i2s_lrck, i2s_data, overrun, underrun, dbg_bit_idx, dbg_fifo_count
   );

endinterface

// File: rtl/audio_i2s_tx_fifo2.sv
// Two-entry sample FIFO. Push and pop in the same clk are judged on the count
// before the clk: a full FIFO accepts the push when it is also popped.
module audio_fifo2
   import audio_i2s_tx_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  audio_sample_t push_data,
   input  logic          pop,
   output audio_sample_t head,
   output logic [1:0]    count,
   output logic          full,
   output logic          empty
);

   audio_sample_t slot0;
   audio_sample_t slot1;
   logic          pop_ok;
   logic          push_ok;
   logic [1:0]    cnt_after;

   assign full      = (count == 2'd2);
   assign empty     = (count == 2'd0);
   assign pop_ok    = pop && !empty;
   assign push_ok   = push && (!full || pop_ok);
   assign cnt_after = count - {1'b0, pop_ok};
   assign head      = slot0;

   // slot0 is always the head; a push lands right behind whatever survives the pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot0 <= '0;
         slot1 <= '0;
         count <= 2'd0;
      end else begin
         if (pop_ok) slot0 <= slot1;
         if (push_ok) begin
            if (cnt_after == 2'd0) slot0 <= push_data;
            else                   slot1 <= push_data;
         end
         count <= cnt_after + {1'b0, push_ok};
      end
   end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: buffers mono samples from the 24 kHz strobe and sends each one
// on both the left and right slots of a 32-BCLK frame, MSB first.
module audio_i2s_tx
   import audio_i2s_tx_pkg::*;
#(
   parameter int BCLK_DIV  = 16,
   parameter bit SIGNED_IN = 1'b0
) (
   input logic           clk,
   input logic           rst,
   audio_i2s_tx_if.slave bus
);

   localparam int               DIV_W    = $clog2(BCLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [4:0]       IDX_LAST = 5'(I2S_FRAME_BITS - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             bclk;
   logic             lrck;
   logic             data;
   logic             overrun_q;
   logic             underrun_q;
   logic [4:0]       bit_idx;
   audio_sample_t    word;
   audio_sample_t    word_next;

   logic             div_tc;
   logic             fall_evt;
   logic             frame_wrap;
   logic [4:0]       new_idx;
   logic [3:0]       bit_sel;
   logic             lrck_next;

   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   audio_sample_t    fifo_head;
   logic [1:0]       fifo_count;

   assign div_tc     = (div_cnt == DIV_LAST);
   assign fall_evt   = div_tc && bclk;
   assign frame_wrap = fall_evt && (bit_idx == IDX_LAST);
   assign new_idx    = bit_idx + 5'd1;
   assign bit_sel    = 4'(I2S_SLOT_BITS - 1) - new_idx[3:0];
   // Word select switches one BCLK ahead of the slot MSB.
   assign lrck_next  = ((new_idx + 5'd1) >= 5'd16);

   assign push = bus.clk_24KHz_en;
   assign pop  = frame_wrap && !fifo_empty;

   audio_fifo2 u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (bus.audio),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // On an empty wrap the previous word repeats; mute overrides whatever is loaded.
   always_comb begin
      word_next = word;
      if (frame_wrap) begin
         if (!fifo_empty) word_next = to_tx_word(fifo_head, SIGNED_IN);
         if (bus.mute)    word_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt    <= '0;
         bclk       <= 1'b0;
         lrck       <= 1'b0;
         data       <= 1'b0;
         overrun_q  <= 1'b0;
         underrun_q <= 1'b0;
         bit_idx    <= IDX_LAST;
         word       <= '0;
      end else begin
         if (div_tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
         if (fall_evt) begin
            bit_idx <= new_idx;
            word    <= word_next;
            data    <= word_next[bit_sel];
            lrck    <= lrck_next;
         end
         overrun_q  <= push && fifo_full && !pop;
         underrun_q <= frame_wrap && fifo_empty;
      end
   end

   assign bus.i2s_bclk       = bclk;
   assign bus.i2s_lrck       = lrck;
   assign bus.i2s_data       = data;
   assign bus.overrun        = overrun_q;
   assign bus.underrun       = underrun_q;
   assign bus.dbg_bit_idx    = bit_idx;
   assign bus.dbg_fifo_count = fifo_count;

endmodule
